ssio_delay_cal: RTL and testbench

//  Calibration controller for a source-synchronous SDR input capture register and its input delay line.

---
 rtl/ssio_delay_cal_window.sv | 75 +++++++
 rtl/ssio_delay_cal.sv | 221 ++++++++++++++++++++++
 tb/tb_ssio_delay_cal.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ssio_delay_cal_window.sv
// Run/best-window tracker for the tap sweep.
// Follows the current run of passing taps and keeps the longest run seen so far.
// Of two equal-length runs, the first one is kept.
module ssio_delay_cal_window #(
    parameter int unsigned TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             eval,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len
);

    logic [TAP_W:0]   run;
    logic [TAP_W:0]   run_n;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W-1:0] run_start_n;
    logic             run_valid;
    logic             run_valid_n;
    logic [TAP_W-1:0] best_start_n;
    logic [TAP_W:0]   best_len_n;

    // Next-state of the run and best-window registers.
    always_comb begin
        run_n        = run;
        run_start_n  = run_start;
        run_valid_n  = run_valid;
        best_start_n = best_start;
        best_len_n   = best_len;
        if (clear) begin
            run_n        = '0;
            run_start_n  = '0;
            run_valid_n  = 1'b0;
            best_start_n = '0;
            best_len_n   = '0;
        end else if (eval) begin
            if (pass) begin
                run_n = run + (TAP_W+1)'(1);
                if (!run_valid) begin
                    run_start_n = tap;
                    run_valid_n = 1'b1;
                end
            end else begin
                run_n       = '0;
                run_valid_n = 1'b0;
            end
            // Strictly greater: a later window of equal length never replaces the first.
            if (run_n > best_len) begin
                best_len_n   = run_n;
                best_start_n = run_start_n;
            end
        end
    end

    // Window registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run        <= '0;
            run_start  <= '0;
            run_valid  <= 1'b0;
            best_start <= '0;
            best_len   <= '0;
        end else begin
            run        <= run_n;
            run_start  <= run_start_n;
            run_valid  <= run_valid_n;
            best_start <= best_start_n;
            best_len   <= best_len_n;
        end
    end

endmodule

// File: rtl/ssio_delay_cal.sv
// Input delay calibration controller for a source-synchronous SDR capture register.
// Sweeps every delay tap, scores it against the training pattern, then loads the
// centre of the longest passing window.
// Optional post-lock error monitor: define SSIO_DELAY_CAL_MONITOR_EN.
module ssio_delay_cal #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned TAPS          = 32,
    parameter int unsigned DEFAULT_TAP   = 0,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [WIDTH-1:0]         data_in,
    output logic [$clog2(TAPS)-1:0]  delay_tap,
    output logic                     delay_load,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [15:0]              err_count
);

    localparam int unsigned TAP_W   = $clog2(TAPS);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_SETTLE = 4'd2;
    localparam logic [3:0] S_SAMPLE = 4'd3;
    localparam logic [3:0] S_EVAL   = 4'd4;
    localparam logic [3:0] S_NEXT   = 4'd5;
    localparam logic [3:0] S_CENTER = 4'd6;
    localparam logic [3:0] S_APPLY  = 4'd7;
    localparam logic [3:0] S_WAIT   = 4'd8;
    localparam logic [3:0] S_FIN    = 4'd9;
`ifdef SSIO_DELAY_CAL_MONITOR_EN
    localparam logic [3:0] S_LOCK   = 4'd10;
`endif

    logic [3:0]       state;
    logic [3:0]       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             miss;
    logic             miss_n;
    logic [TAP_W-1:0] tap_n;
    logic             load_n;
    logic             busy_n;
    logic             done_n;
    logic             fail_n;
    logic             start_ok_c;
    logic             win_clear_c;
    logic             win_eval_c;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   best_len;

    // A start is honoured only when no calibration is in flight.
`ifdef SSIO_DELAY_CAL_MONITOR_EN
    assign start_ok_c = start && ((state == S_IDLE) || (state == S_LOCK));
`else
    assign start_ok_c = start && (state == S_IDLE);
`endif

    // Longest passing window tracker.
    ssio_delay_cal_window #(
        .TAP_W (TAP_W)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .clear      (win_clear_c),
        .eval       (win_eval_c),
        .pass       (!miss),
        .tap        (delay_tap),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // Next-state and next-output logic; delay_load is raised on entry to LOAD/APPLY.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        miss_n      = miss;
        tap_n       = delay_tap;
        load_n      = 1'b0;
        busy_n      = busy;
        done_n      = done;
        fail_n      = fail;
        win_clear_c = 1'b0;
        win_eval_c  = 1'b0;
        case (state)
            S_IDLE: begin
            end
            S_LOAD: begin
                state_n = S_SETTLE;
                cnt_n   = '0;
                miss_n  = 1'b0;
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_n = S_SAMPLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (data_in != pattern) begin
                    miss_n = 1'b1;
                end
                if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    state_n = S_EVAL;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_EVAL: begin
                win_eval_c = 1'b1;
                state_n    = S_NEXT;
            end
            S_NEXT: begin
                if (delay_tap != TAP_W'(TAPS - 1)) begin
                    tap_n   = delay_tap + TAP_W'(1);
                    load_n  = 1'b1;
                    state_n = S_LOAD;
                end else begin
                    state_n = S_CENTER;
                end
            end
            S_CENTER: begin
                if (best_len != '0) begin
                    tap_n = TAP_W'({1'b0, best_start} + (best_len >> 1));
                end else begin
                    tap_n = TAP_W'(DEFAULT_TAP);
                end
                load_n  = 1'b1;
                state_n = S_APPLY;
            end
            S_APPLY: begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = S_FIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_FIN: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
                if (best_len != '0) begin
                    done_n = 1'b1;
`ifdef SSIO_DELAY_CAL_MONITOR_EN
                    state_n = S_LOCK;
`endif
                end else begin
                    fail_n = 1'b1;
                end
            end
`ifdef SSIO_DELAY_CAL_MONITOR_EN
            S_LOCK: begin
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (start_ok_c) begin
            state_n     = S_LOAD;
            tap_n       = '0;
            load_n      = 1'b1;
            busy_n      = 1'b1;
            done_n      = 1'b0;
            fail_n      = 1'b0;
            win_clear_c = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            miss       <= 1'b0;
            delay_tap  <= TAP_W'(DEFAULT_TAP);
            delay_load <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            miss       <= miss_n;
            delay_tap  <= tap_n;
            delay_load <= load_n;
            busy       <= busy_n;
            done       <= done_n;
            fail       <= fail_n;
        end
    end

`ifdef SSIO_DELAY_CAL_MONITOR_EN
    // Post-lock mismatch counter, saturating.
    always_ff @(posedge clk) begin
        if (rst || start_ok_c) begin
            err_count <= '0;
        end else if ((state == S_LOCK) && (data_in != pattern) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ssio_delay_cal.sv
// Directed bench for ssio_delay_cal with a behavioural delay line / training source.
// Build with SSIO_DELAY_CAL_MONITOR_EN defined to exercise the post-lock counter.
module tb_ssio_delay_cal;

    localparam int unsigned W       = 8;
    localparam int unsigned TAPS    = 32;
    localparam int unsigned SETTLE  = 8;
    localparam int unsigned SAMPLE  = 64;
    localparam int unsigned DEF_TAP = 16;
    localparam int LATENCY = TAPS * (SETTLE + SAMPLE + 3) + 2 + 1 + SETTLE + 1;
    localparam logic [W-1:0] PAT = 8'hA5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [4:0]   delay_tap;
    logic         delay_load;
    logic         busy;
    logic         done;
    logic         fail;
    logic [15:0]  err_count;

    int checks   = 0;
    int failures = 0;

    // Delay line / training source model.
    logic [31:0] pass_mask  = 32'h0;
    int          glitch_tap = -1;
    logic        force_bad  = 1'b0;
    logic [4:0]  line_tap   = 5'd16;
    int          since      = 0;
    int          load_cnt   = 0;
    int          dbl_load   = 0;
    logic        prev_load  = 1'b0;

    always #5 clk = ~clk;

    ssio_delay_cal #(
        .WIDTH         (W),
        .TAPS          (TAPS),
        .DEFAULT_TAP   (DEF_TAP),
        .SETTLE_CYCLES (SETTLE),
        .SAMPLE_CYCLES (SAMPLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (PAT),
        .data_in    (data_in),
        .delay_tap  (delay_tap),
        .delay_load (delay_load),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .err_count  (err_count)
    );

    // Delay line latches the tap on delay_load; 'since' counts cycles after the load.
    always @(posedge clk) begin
        if (delay_load) begin
            line_tap <= delay_tap;
            since    <= 0;
            load_cnt <= load_cnt + 1;
        end else begin
            since <= since + 1;
        end
        if (delay_load && prev_load) dbl_load <= dbl_load + 1;
        prev_load <= delay_load;
    end

    // 64th sample of a tap lands at since == SETTLE + SAMPLE - 1.
    assign data_in = (force_bad || !pass_mask[line_tap] ||
                      ((int'(line_tap) == glitch_tap) && (since == int'(SETTLE + SAMPLE - 1))))
                     ? ~PAT : PAT;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m;
        m = 32'h0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Full calibration: optional start poke at cycle poke_cyc, checks result and latency.
    task automatic run_cal(input string tag, input logic [31:0] mask, input int glitch,
                           input int poke_cyc, input logic [4:0] exp_tap, input logic exp_done);
        int n;
        int base;
        pass_mask  = mask;
        glitch_tap = glitch;
        @(negedge clk);
        base  = load_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_err_clr"}, err_count, 16'h0);
        while (!(done || fail) && n < 5000) begin
            if (n == poke_cyc) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_latency"}, n, LATENCY);
        check({tag, "_tap"}, delay_tap, exp_tap);
        check({tag, "_line_tap"}, line_tap, exp_tap);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_fail"}, fail, !exp_done);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_loads"}, load_cnt - base, TAPS + 1);
        glitch_tap = -1;
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tap", delay_tap, 5'd16);
        check("rst_load", delay_load, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fail", fail, 1'b0);
        check("rst_err", err_count, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        run_cal("w10_20", win(10, 20), -1, -1, 5'd15, 1'b1);

        // Mismatches after lock.
        @(negedge clk);
        force_bad = 1'b1;
        repeat (3) @(negedge clk);
        force_bad = 1'b0;
        @(posedge clk); #1;
`ifdef SSIO_DELAY_CAL_MONITOR_EN
        check("mon_err3", err_count, 16'd3);
`else
        check("nomon_err0", err_count, 16'd0);
`endif
        check("lock_done", done, 1'b1);

        run_cal("w3_5_20_27", win(3, 5) | win(20, 27), -1, -1, 5'd24, 1'b1);
        run_cal("equal_win", win(2, 4) | win(8, 10), -1, -1, 5'd3, 1'b1);
        run_cal("w28_31", win(28, 31), -1, -1, 5'd30, 1'b1);
        run_cal("all_pass", 32'hFFFF_FFFF, -1, -1, 5'd16, 1'b1);
        run_cal("none_pass", 32'h0, -1, -1, 5'd16, 1'b0);
        run_cal("glitch64", win(4, 9), 9, -1, 5'd6, 1'b1);

        // Reset in the middle of tap 12's sample phase.
        pass_mask = win(10, 20);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 939) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_tap12", delay_tap, 5'd12);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_load", delay_load, 1'b0);
        check("rst_mid_tap", delay_tap, 5'd16);
        check("rst_mid_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Restart after reset, with an ignored start at tap 5.
        run_cal("poke_t5", win(10, 20), -1, 5 * 75 + 40, 5'd15, 1'b1);

`ifdef SSIO_DELAY_CAL_MONITOR_EN
        @(negedge clk);
        force_bad = 1'b1;
        repeat (70000) @(negedge clk);
        force_bad = 1'b0;
        @(posedge clk); #1;
        check("mon_sat", err_count, 16'hFFFF);
        check("mon_sat_done", done, 1'b1);
`endif

        check("no_dbl_load", dbl_load, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
